// File: rtl/zf_dm_pkg.sv
// Shared constants for the datamover command/status scheduler: command field
// offsets, status bit positions and the scheduler state type.
package zf_dm_pkg;

   localparam int CMD_WIDTH  = 72;
   localparam int STS_WIDTH  = 8;
   localparam int TAG_LSB    = 64;
   localparam int ADDR_LSB   = 32;
   localparam int EOF_BIT    = 30;
   localparam int TYPE_BIT   = 23;
   localparam int BTT_WIDTH  = 23;

   localparam int STS_OK     = 7;
   localparam int STS_SLVERR = 6;
   localparam int STS_DECERR = 5;
   localparam int STS_INTERR = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } sched_state_t;

   // Single-descriptor INCR command with EOF set, DRR and DSA left at zero.
   function automatic logic [CMD_WIDTH-1:0] build_cmd(input logic [3:0]           tag,
                                                      input logic [31:0]          addr,
                                                      input logic [BTT_WIDTH-1:0] btt);
      logic [CMD_WIDTH-1:0] c;
      c                   = '0;
      c[TAG_LSB +: 4]     = tag;
      c[ADDR_LSB +: 32]   = addr;
      c[EOF_BIT]          = 1'b1;
      c[TYPE_BIT]         = 1'b1;
      c[BTT_WIDTH-1:0]    = btt;
      return c;
   endfunction

endpackage

// File: rtl/zf_dm_cmd_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i,
// wrapping around the 2**W requesters.
module zf_rr_pick #(
   parameter int W = 2
) (
   input  logic [(1<<W)-1:0] req_i,
   input  logic [W-1:0]      ptr_i,
   output logic [W-1:0]      grant_o,
   output logic              valid_o
);

   localparam int N = 1 << W;

   logic [W-1:0] idx;

   // Walk from the farthest offset down so the nearest request wins last.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr_i + W'(k);
         if (req_i[idx]) begin
            grant_o = idx;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/zf_dm_cmd_scheduler.sv
// Shares one datamover cmd/sts channel pair between 2**STREAMS_WIDTH requesters,
// tagging each command with its stream and routing statuses back by tag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | looking for a grant candidate (no halt, below outstanding cap)
// ST_ISSUE | command registered, cmd_tvalid held until cmd_tready
module zf_dm_cmd_scheduler
   import zf_dm_pkg::*;
#(
   parameter int STREAMS_WIDTH   = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int USE_EXT_SEL     = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [(1<<STREAMS_WIDTH)-1:0]       req_valid,
   input  logic [(1<<STREAMS_WIDTH)*32-1:0]    req_addr,
   input  logic [(1<<STREAMS_WIDTH)*23-1:0]    req_btt,
   output logic [(1<<STREAMS_WIDTH)-1:0]       req_ready,
   input  logic [STREAMS_WIDTH-1:0]            ext_stream_sel,
   input  logic                                ext_stream_valid,
   output logic [71:0]                         cmd_tdata,
   output logic                                cmd_tvalid,
   input  logic                                cmd_tready,
   input  logic [7:0]                          sts_tdata,
   input  logic                                sts_tvalid,
   output logic                                sts_tready,
   output logic [(1<<STREAMS_WIDTH)-1:0]       done_valid,
   output logic [(1<<STREAMS_WIDTH)-1:0]       done_err,
   input  logic [(1<<STREAMS_WIDTH)-1:0]       done_ready,
   input  logic                                halt,
   output logic                                halt_cmplt,
   output logic [3:0]                          outstanding,
   output logic [15:0]                         err_count,
   output logic                                busy
);

   localparam int SW = STREAMS_WIDTH;
   localparam int N  = 1 << SW;

   sched_state_t         state_q, state_d;
   logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [SW-1:0]        grant_q, grant_d;
   logic [31:0]          addr_q, addr_d, addr_sel;
   logic [BTT_WIDTH-1:0] btt_q, btt_d, btt_sel;
   logic [3:0]           out_q, out_d;
   logic [15:0]          err_q, err_d;
   logic [N-1:0]         dv_q, dv_d, de_q, de_d;

   logic [SW-1:0]        rr_grant, cand;
   logic                 rr_valid, cand_valid;
   logic                 cmd_hs, sts_hs, sts_bad;
   logic [SW-1:0]        sts_idx;
   logic                 unused_sts_bits;

   zf_rr_pick #(.W(SW)) u_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (rr_grant),
      .valid_o (rr_valid)
   );

   assign cand       = (USE_EXT_SEL != 0) ? ext_stream_sel : rr_grant;
   assign cand_valid = (USE_EXT_SEL != 0) ? (ext_stream_valid && req_valid[ext_stream_sel])
                                          : rr_valid;

   always_comb begin
      addr_sel = '0;
      btt_sel  = '0;
      for (int i = 0; i < N; i++) begin
         if (cand == SW'(i)) begin
            addr_sel = req_addr[32*i +: 32];
            btt_sel  = req_btt[BTT_WIDTH*i +: BTT_WIDTH];
         end
      end
   end

   // Only the low SW tag bits select a stream; the rest are ignored.
   assign sts_idx         = sts_tdata[SW-1:0];
   assign unused_sts_bits = ^sts_tdata;

   assign cmd_hs  = (state_q == ST_ISSUE) && cmd_tready;
   assign sts_hs  = sts_tvalid && sts_tready;
   assign sts_bad = (sts_tdata[STS_SLVERR:STS_INTERR] != 3'b000) || !sts_tdata[STS_OK]
                    || (out_q == 4'd0);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      btt_d    = btt_q;
      out_d    = out_q;
      err_d    = err_q;
      dv_d     = dv_q;
      de_d     = de_q;

      case (state_q)
         ST_IDLE: begin
            if (!halt && (out_q < 4'(MAX_OUTSTANDING)) && cand_valid) begin
               grant_d = cand;
               addr_d  = addr_sel;
               btt_d   = btt_sel;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_tready) begin
               rr_ptr_d = grant_q + 1'b1;
               state_d  = ST_IDLE;
            end
         end
      endcase

      // A status with nothing in flight must not wrap the counter.
      case ({cmd_hs, sts_hs && (out_q != 4'd0)})
         2'b10:   out_d = out_q + 4'd1;
         2'b01:   out_d = out_q - 4'd1;
         default: out_d = out_q;
      endcase

      if (sts_hs && sts_bad && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;

      for (int i = 0; i < N; i++) begin
         if (sts_hs && (sts_idx == SW'(i))) begin
            dv_d[i] = 1'b1;
            de_d[i] = !sts_tdata[STS_OK];
         end else if (done_ready[i]) begin
            dv_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         btt_q    <= '0;
         out_q    <= '0;
         err_q    <= '0;
         dv_q     <= '0;
         de_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         btt_q    <= btt_d;
         out_q    <= out_d;
         err_q    <= err_d;
         dv_q     <= dv_d;
         de_q     <= de_d;
      end
   end

   assign cmd_tvalid  = (state_q == ST_ISSUE);
   assign cmd_tdata   = build_cmd(4'(grant_q), addr_q, btt_q);
   assign req_ready   = cmd_hs ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
   assign sts_tready  = rst_n && (!dv_q[sts_idx] || done_ready[sts_idx]);
   assign done_valid  = dv_q;
   assign done_err    = de_q;
   assign outstanding = out_q;
   assign err_count   = err_q;
   assign halt_cmplt  = rst_n && halt && (out_q == 4'd0) && (state_q == ST_IDLE);
   assign busy        = (out_q != 4'd0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_zf_dm_cmd_scheduler.sv
// Directed bench for zf_dm_cmd_scheduler: a transaction-level model checked every
// cycle on the round-robin instance, plus literal checks on both instances.
module tb_zf_dm_cmd_scheduler;

   localparam int SW   = 2;
   localparam int N    = 4;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_ready;
   logic [N*32-1:0] req_addr;
   logic [N*23-1:0] req_btt;
   logic [71:0]     cmd_tdata;
   logic            cmd_tvalid, cmd_tready;
   logic [7:0]      sts_tdata;
   logic            sts_tvalid, sts_tready;
   logic [N-1:0]    done_valid, done_err, done_ready;
   logic            halt, halt_cmplt, busy;
   logic [3:0]      outstanding;
   logic [15:0]     err_count;

   logic [N-1:0]    x_req_valid, x_req_ready;
   logic [SW-1:0]   x_ext_sel;
   logic            x_ext_valid;
   logic [71:0]     x_cmd_tdata;
   logic            x_cmd_tvalid, x_cmd_tready, x_sts_tready;
   logic [N-1:0]    x_done_valid, x_done_err;
   logic            x_halt_cmplt, x_busy;
   logic [3:0]      x_outstanding;
   logic [15:0]     x_err_count;

   zf_dm_cmd_scheduler #(.STREAMS_WIDTH(SW), .MAX_OUTSTANDING(MAXO), .USE_EXT_SEL(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_btt(req_btt),
      .req_ready(req_ready), .ext_stream_sel(2'd0), .ext_stream_valid(1'b0),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
      .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
      .done_valid(done_valid), .done_err(done_err), .done_ready(done_ready),
      .halt(halt), .halt_cmplt(halt_cmplt), .outstanding(outstanding),
      .err_count(err_count), .busy(busy));

   zf_dm_cmd_scheduler #(.STREAMS_WIDTH(SW), .MAX_OUTSTANDING(15), .USE_EXT_SEL(1)) dut_x (
      .clk(clk), .rst_n(rst_n), .req_valid(x_req_valid), .req_addr(req_addr), .req_btt(req_btt),
      .req_ready(x_req_ready), .ext_stream_sel(x_ext_sel), .ext_stream_valid(x_ext_valid),
      .cmd_tdata(x_cmd_tdata), .cmd_tvalid(x_cmd_tvalid), .cmd_tready(x_cmd_tready),
      .sts_tdata(8'h00), .sts_tvalid(1'b0), .sts_tready(x_sts_tready),
      .done_valid(x_done_valid), .done_err(x_done_err), .done_ready(4'b0000),
      .halt(1'b0), .halt_cmplt(x_halt_cmplt), .outstanding(x_outstanding),
      .err_count(x_err_count), .busy(x_busy));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: at most one registered command, a count of in-flight commands,
   // a rotating priority pointer and per-stream completion slots.
   bit          m_pend;
   int          m_tag, m_ptr, m_out, m_err;
   logic [31:0] m_addr;
   logic [22:0] m_btt;
   bit [N-1:0]  m_dv, m_de;

   bit          s_hs, c_hs;
   logic [3:0]  c_tag;
   int          tag_log[$];
   int          x_tag_log[$];

   always @(negedge clk) begin : compare
      int s, idx, old_out;
      bit e_str, chs, shs;
      logic [N-1:0] e_rr;
      if (!rst_n) begin
         m_pend = 0; m_tag = 0; m_ptr = 0; m_out = 0; m_err = 0; m_dv = '0; m_de = '0;
         s_hs = 0; c_hs = 0; c_tag = '0;
      end else begin
         s     = int'(sts_tdata[SW-1:0]);
         e_str = !m_dv[s] || done_ready[s];
         e_rr  = (m_pend && cmd_tready) ? N'(1 << m_tag) : '0;
         chk("cmd_tvalid", cmd_tvalid, m_pend);
         if (m_pend)
            chk("cmd_tdata", cmd_tdata,
                (72'(m_tag) << 64) | (72'(m_addr) << 32) | 72'h4080_0000 | 72'(m_btt));
         chk("req_ready", req_ready, e_rr);
         chk("sts_tready", sts_tready, e_str);
         chk("done_valid", done_valid, m_dv);
         chk("done_err", done_err, m_de);
         chk("outstanding", outstanding, 72'(m_out));
         chk("err_count", err_count, 72'(m_err));
         chk("halt_cmplt", halt_cmplt, halt && m_out == 0 && !m_pend);
         chk("busy", busy, m_out != 0 || m_pend);

         c_hs  = cmd_tvalid && cmd_tready;
         c_tag = cmd_tdata[67:64];
         s_hs  = sts_tvalid && sts_tready;
         if (c_hs) tag_log.push_back(int'(c_tag));

         chs     = m_pend && cmd_tready;
         shs     = sts_tvalid && e_str;
         old_out = m_out;
         if (shs && (sts_tdata[6:4] != 0 || !sts_tdata[7] || old_out == 0) && m_err < 65535)
            m_err++;
         for (int i = 0; i < N; i++) begin
            if (shs && s == i) begin
               m_dv[i] = 1'b1;
               m_de[i] = !sts_tdata[7];
            end else if (done_ready[i]) begin
               m_dv[i] = 1'b0;
            end
         end
         m_out = old_out + (chs ? 1 : 0) - ((shs && old_out > 0) ? 1 : 0);
         if (chs) begin
            m_ptr  = (m_tag + 1) % N;
            m_pend = 0;
         end else if (!m_pend && !halt && old_out < MAXO) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (req_valid[idx]) begin
                  m_pend = 1;
                  m_tag  = idx;
                  m_addr = req_addr[32*idx +: 32];
                  m_btt  = req_btt[23*idx +: 23];
                  break;
               end
            end
         end
      end
      if (rst_n && x_cmd_tvalid && x_cmd_tready) x_tag_log.push_back(int'(x_cmd_tdata[67:64]));
   end

   logic [7:0] sq[$];
   bit         auto_sts;

   task automatic step();
      @(posedge clk);
      #1;
      if (s_hs && sq.size() > 0) void'(sq.pop_front());
      if (c_hs && auto_sts) sq.push_back({4'h8, c_tag});
      sts_tvalid = (sq.size() != 0);
      sts_tdata  = (sq.size() != 0) ? sq[0] : 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sq.delete();
      auto_sts = 0;
      sts_tvalid = 1'b0; sts_tdata = 8'h00;
      req_valid = '0; cmd_tready = 1'b0; halt = 1'b0; done_ready = '0;
      x_req_valid = '0; x_ext_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int base, n;
      int exp_tags[5];
      exp_tags = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) begin
         req_addr[32*i +: 32] = 32'h2000_0000 + 32'(i * 256);
         req_btt[23*i +: 23]  = 23'(64 * (i + 1));
      end
      req_addr[64 +: 32] = 32'h1000_0040;
      req_btt[46 +: 23]  = 23'd512;
      x_ext_sel = 2'd3; x_cmd_tready = 1'b1;
      rst_n = 1'b0; sts_tvalid = 1'b0; sts_tdata = 8'h00; auto_sts = 0;
      req_valid = '0; cmd_tready = 1'b0; halt = 1'b0; done_ready = '0;
      x_req_valid = '0; x_ext_valid = 1'b0;

      // reset values
      #3;
      chk("rst_cmd_tvalid", cmd_tvalid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_sts_tready", sts_tready, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halt_cmplt", halt_cmplt, 0);
      do_reset();

      // command format, stream 2
      req_valid = 4'b0100;
      step();
      chk("fmt_tvalid", cmd_tvalid, 1);
      chk("fmt_tdata", cmd_tdata, 72'h02_1000_0040_4080_0200);
      step(); step();
      chk("fmt_hold", cmd_tdata, 72'h02_1000_0040_4080_0200);
      cmd_tready = 1'b1;
      #1 chk("fmt_req_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      chk("fmt_outstanding", outstanding, 1);
      sq.push_back(8'h82);
      step(); step();
      chk("fmt_done_valid", done_valid, 4'b0100);
      chk("fmt_done_err", done_err, 4'b0000);
      chk("fmt_out_zero", outstanding, 0);
      done_ready = 4'b0100; step(); done_ready = '0;

      // round-robin fairness with immediate status return
      do_reset();
      base = tag_log.size();
      auto_sts = 1; cmd_tready = 1'b1; done_ready = 4'hF; req_valid = 4'hF;
      repeat (10) step();
      req_valid = '0;
      repeat (3) step();
      chk("rr_count", tag_log.size() - base, 5);
      for (int k = 0; k < 5; k++)
         chk("rr_tag", (base + k < tag_log.size()) ? tag_log[base + k] : 15, exp_tags[k]);
      auto_sts = 0; done_ready = '0;

      // outstanding limit
      do_reset();
      base = tag_log.size();
      cmd_tready = 1'b1; req_valid = 4'hF;
      repeat (12) step();
      chk("lim_count", tag_log.size() - base, 4);
      chk("lim_outstanding", outstanding, 4);
      chk("lim_tvalid", cmd_tvalid, 0);
      sq.push_back(8'h81);
      step(); step();
      chk("lim_out_after_sts", outstanding, 3);
      chk("lim_done_valid", done_valid, 4'b0010);
      repeat (3) step();
      chk("lim_count5", tag_log.size() - base, 5);
      chk("lim_tag5", (tag_log.size() > base + 4) ? tag_log[base + 4] : 15, 0);
      chk("lim_outstanding4", outstanding, 4);
      req_valid = '0;

      // error status and completion backpressure
      done_ready = 4'b0010; step(); done_ready = '0;
      sq.push_back(8'h41);
      step(); step();
      chk("err_done_valid", done_valid, 4'b0010);
      chk("err_done_err", done_err, 4'b0010);
      chk("err_count1", err_count, 1);
      chk("err_outstanding", outstanding, 3);
      sq.push_back(8'h81);
      step();
      #1 chk("bp_sts_tready", sts_tready, 0);
      step(); step();
      chk("bp_sts_tready_held", sts_tready, 0);
      chk("bp_outstanding", outstanding, 3);
      done_ready = 4'b0010;
      #1 chk("bp_release", sts_tready, 1);
      step();
      done_ready = '0;
      chk("bp_done_valid", done_valid, 4'b0010);
      chk("bp_done_err", done_err, 4'b0000);
      chk("bp_outstanding2", outstanding, 2);

      // halt during ISSUE with two outstanding
      req_valid = 4'b0001; cmd_tready = 1'b0;
      step();
      chk("halt_issue", cmd_tvalid, 1);
      halt = 1'b1;
      step();
      chk("halt_hold", cmd_tvalid, 1);
      chk("halt_cmplt_busy", halt_cmplt, 0);
      cmd_tready = 1'b1;
      #1 chk("halt_req_ready", req_ready, 4'b0001);
      step();
      chk("halt_outstanding3", outstanding, 3);
      req_valid = 4'hF; done_ready = 4'hF;
      sq.push_back(8'h80); sq.push_back(8'h82); sq.push_back(8'h83);
      for (int t = 0; t < 12 && sq.size() != 0; t++) step();
      chk("halt_drain", sq.size(), 0);
      chk("halt_cmplt", halt_cmplt, 1);
      chk("halt_out0", outstanding, 0);
      chk("halt_busy", busy, 0);
      repeat (3) step();
      chk("halt_no_cmd", cmd_tvalid, 0);
      halt = 1'b0;
      step(); step();
      chk("resume_tag", (tag_log.size() > 0) ? tag_log[tag_log.size() - 1] : 15, 1);
      req_valid = '0; done_ready = '0;

      // external select instance
      x_req_valid = 4'hF;
      repeat (3) step();
      chk("ext_idle", x_cmd_tvalid, 0);
      base = x_tag_log.size();
      x_ext_valid = 1'b1;
      repeat (8) step();
      n = x_tag_log.size() - base;
      chk("ext_count", n, 4);
      for (int k = 0; k < n; k++) chk("ext_tag", x_tag_log[base + k], 3);

      // asynchronous reset while a command is held
      req_valid = 4'b0100; cmd_tready = 1'b0;
      step();
      chk("arst_pre", cmd_tvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", cmd_tvalid, 0);
      chk("arst_outstanding", outstanding, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_busy", busy, 0);
      chk("arst_x_outstanding", x_outstanding, 0);
      req_valid = '0; x_req_valid = '0; x_ext_valid = 1'b0; sq.delete();
      sts_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
